// File: rtl/multiexp_kernel_ctrl.sv
// Kernel-level control sequencer for the multiexp accelerator: host start/idle/ready/done
// handshake (ap_ctrl_hs or ap_ctrl_chain), argument latching and per-channel byte counts.
module multiexp_kernel_ctrl #(
    parameter int                        NUM_RD_CH     = 2,
    parameter int                        NUM_DONE      = 1,
    parameter logic [32*NUM_RD_CH-1:0]   RD_ELEM_BYTES = {32'd32, 32'd64},
    parameter int                        XFER_W        = 64,
    parameter bit                        CTRL_CHAIN    = 1'b1
) (
    input  logic                          ap_clk,
    input  logic                          ap_rst_n,
    input  logic                          ap_start,
    input  logic                          ap_continue,
    output logic                          ap_idle,
    output logic                          ap_ready,
    output logic                          ap_done,
    input  logic [63:0]                   num_in,
    input  logic [64*NUM_RD_CH-1:0]       base_addr,
    output logic                          o_start,
    output logic [63:0]                   o_num_in,
    output logic [64*NUM_RD_CH-1:0]       o_addr,
    output logic [XFER_W*NUM_RD_CH-1:0]   o_xfer_bytes,
    input  logic [NUM_DONE-1:0]           i_done,
    output logic                          o_err,
    output logic [31:0]                   o_busy_cycles
);

    localparam int PROD_W = 96;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_START,
        S_RUN,
        S_DONE
    } state_t;

    state_t                        state;
    state_t                        state_nx;
    logic [1:0]                    rst_sync;
    logic                          rst_n;
    logic [NUM_DONE-1:0]           done_sticky;
    logic                          done_all;
    logic                          any_ovf;
    logic                          num_zero;
    logic [PROD_W-1:0]             prod [NUM_RD_CH];
    logic [XFER_W*NUM_RD_CH-1:0]   xfer_nx;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    // Reset asserts immediately but releases two clocks after ap_rst_n rises.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    // Byte counts are formed from the already-latched element count during LATCH.
    always_comb begin
        any_ovf = 1'b0;
        xfer_nx = '0;
        for (int k = 0; k < NUM_RD_CH; k++) begin
            prod[k] = PROD_W'(o_num_in) * PROD_W'(RD_ELEM_BYTES[32*k +: 32]);
            xfer_nx[XFER_W*k +: XFER_W] = prod[k][XFER_W-1:0];
            for (int b = 0; b < PROD_W; b++) begin
                if (b >= XFER_W && prod[k][b]) begin
                    any_ovf = 1'b1;
                end
            end
        end
    end

    assign num_zero = (o_num_in == 64'd0);
    assign done_all = &(done_sticky | i_done);

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (ap_start) state_nx = S_LATCH;
            S_LATCH: state_nx = (any_ovf || num_zero) ? S_DONE : S_START;
            S_START,
            S_RUN:   state_nx = done_all ? S_DONE : S_RUN;
            S_DONE:  if (!CTRL_CHAIN || ap_continue) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Handshake outputs are registered copies of the state being entered.
    always_ff @(posedge ap_clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            ap_idle  <= 1'b1;
            ap_ready <= 1'b0;
            ap_done  <= 1'b0;
            o_start  <= 1'b0;
        end else begin
            state    <= state_nx;
            ap_idle  <= (state_nx == S_IDLE);
            ap_ready <= (state == S_LATCH);
            ap_done  <= (state_nx == S_DONE);
            o_start  <= (state_nx == S_START);
        end
    end

    always_ff @(posedge ap_clk or negedge rst_n) begin
        if (!rst_n) begin
            o_num_in      <= '0;
            o_addr        <= '0;
            o_xfer_bytes  <= '0;
            o_err         <= 1'b0;
            o_busy_cycles <= '0;
            done_sticky   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ap_start) begin
                        o_num_in      <= num_in;
                        o_addr        <= base_addr;
                        o_err         <= 1'b0;
                        o_busy_cycles <= '0;
                        done_sticky   <= '0;
                    end
                end
                S_LATCH: begin
                    o_xfer_bytes <= xfer_nx;
                    o_err        <= any_ovf;
                end
                S_START,
                S_RUN: begin
                    done_sticky   <= done_sticky | i_done;
                    o_busy_cycles <= sat_inc(o_busy_cycles);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multiexp_kernel_ctrl.sv
// Directed bench for multiexp_kernel_ctrl: a default-parameter instance driven from a vector
// table, and a 3-sink / 16-bit / ap_ctrl_hs instance driven by hand-written sequences.
module tb_multiexp_kernel_ctrl;

    logic ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    logic rst_n = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    logic         a_start, a_cont, a_idle, a_ready, a_done, a_ostart, a_err;
    logic [63:0]  a_num, a_onum;
    logic [127:0] a_base, a_oaddr, a_xfer;
    logic [0:0]   a_idone;
    logic [31:0]  a_busy;

    logic         b_start, b_cont, b_idle, b_ready, b_done, b_ostart, b_err;
    logic [63:0]  b_num, b_onum;
    logic [127:0] b_base, b_oaddr;
    logic [31:0]  b_xfer;
    logic [2:0]   b_idone;
    logic [31:0]  b_busy;

    multiexp_kernel_ctrl dut_a (
        .ap_clk(ap_clk), .ap_rst_n(rst_n), .ap_start(a_start), .ap_continue(a_cont),
        .ap_idle(a_idle), .ap_ready(a_ready), .ap_done(a_done), .num_in(a_num),
        .base_addr(a_base), .o_start(a_ostart), .o_num_in(a_onum), .o_addr(a_oaddr),
        .o_xfer_bytes(a_xfer), .i_done(a_idone), .o_err(a_err), .o_busy_cycles(a_busy)
    );

    multiexp_kernel_ctrl #(
        .NUM_DONE(3), .XFER_W(16), .CTRL_CHAIN(1'b0)
    ) dut_b (
        .ap_clk(ap_clk), .ap_rst_n(rst_n), .ap_start(b_start), .ap_continue(b_cont),
        .ap_idle(b_idle), .ap_ready(b_ready), .ap_done(b_done), .num_in(b_num),
        .base_addr(b_base), .o_start(b_ostart), .o_num_in(b_onum), .o_addr(b_oaddr),
        .o_xfer_bytes(b_xfer), .i_done(b_idone), .o_err(b_err), .o_busy_cycles(b_busy)
    );

    int a_start_cnt = 0;
    int a_done_cnt = 0;
    int b_start_cnt = 0;
    always @(negedge ap_clk) begin
        if (a_ostart === 1'b1) a_start_cnt <= a_start_cnt + 1;
        if (a_done === 1'b1)   a_done_cnt  <= a_done_cnt + 1;
        if (b_ostart === 1'b1) b_start_cnt <= b_start_cnt + 1;
    end

    typedef struct {
        logic [63:0] num;
        int          dly;
        int          hold;
        bit          skip;
        bit          err;
        logic [63:0] x0;
        logic [63:0] x1;
        logic [31:0] busy;
    } vec_t;

    vec_t vecs [6];

    task automatic step;
        @(posedge ap_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_a(input vec_t v);
        int           s0;
        int           n;
        bit           early;
        logic [127:0] base;
        base    = {v.num ^ 64'hA5A5_0000_0000_1000, 64'h0000_1000_0000_0040 + v.num};
        s0      = a_start_cnt;
        a_num   = v.num;
        a_base  = base;
        a_start = 1'b1;
        step;
        chk("idle_fall", a_idle, 0);
        a_start = 1'b0;
        a_num   = '1;
        a_base  = '1;
        step;
        chk("ready", a_ready, 1);
        chk("ostart", a_ostart, !v.skip);
        chk("done_t2", a_done, v.skip);
        chk("xfer0", a_xfer[63:0], v.x0);
        chk("xfer1", a_xfer[127:64], v.x1);
        chk("err", a_err, v.err);
        chk("num_latched", a_onum, v.num);
        chk("addr_latched", a_oaddr, base);
        if (!v.skip) begin
            early = 1'b0;
            for (int i = 0; i < v.dly; i++) begin
                step;
                if (a_done) early = 1'b1;
            end
            a_idone = 1'b1;
            step;
            a_idone = 1'b0;
            chk("no_early_done", early, 0);
            chk("done_latency", a_done, 1);
        end
        n = 0;
        while (a_done && n < 40) begin
            n++;
            a_cont = (n > v.hold);
            step;
        end
        chk("done_len", n, v.hold + 1);
        chk("idle_rise", a_idle, 1);
        chk("busy", a_busy, v.busy);
        chk("start_cnt", a_start_cnt - s0, v.skip ? 0 : 1);
        a_cont = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] obs_start, obs_done, obs_idle;
        bit         early;
        int         s0;
        int         d0;

        vecs[0] = '{64'd100, 20, 0, 1'b0, 1'b0, 64'd6400, 64'd3200, 32'd21};
        vecs[1] = '{64'd5, 3, 4, 1'b0, 1'b0, 64'd320, 64'd160, 32'd4};
        vecs[2] = '{64'd0, 0, 0, 1'b1, 1'b0, 64'd0, 64'd0, 32'd0};
        vecs[3] = '{64'h0400_0000_0000_0000, 0, 2, 1'b1, 1'b1, 64'd0,
                    64'h8000_0000_0000_0000, 32'd0};
        vecs[4] = '{64'h03FF_FFFF_FFFF_FFFF, 0, 0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFC0,
                    64'h7FFF_FFFF_FFFF_FFE0, 32'd1};
        vecs[5] = '{64'd1, 0, 0, 1'b0, 1'b0, 64'd64, 64'd32, 32'd1};

        a_start = 0; a_cont = 1; a_num = '0; a_base = '0; a_idone = '0;
        b_start = 0; b_cont = 0; b_num = '0; b_base = '0; b_idone = '0;
        rst_n = 1'b0;
        repeat (3) step;
        chk("rst_a_idle", a_idle, 1);
        chk("rst_a_done", a_done, 0);
        chk("rst_a_ready", a_ready, 0);
        chk("rst_a_ostart", a_ostart, 0);
        chk("rst_a_xfer", a_xfer, 0);
        chk("rst_a_busy", a_busy, 0);
        chk("rst_b_idle", b_idle, 1);
        chk("rst_b_err", b_err, 0);
        rst_n = 1'b1;
        repeat (4) step;

        for (int i = 0; i < 6; i++) run_a(vecs[i]);

        // reset asserted during RUN
        a_num = 64'd7; a_base = 128'h1234; a_start = 1'b1;
        step;
        a_start = 1'b0;
        step;
        chk("rst_mid_ostart", a_ostart, 1);
        step;
        step;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_idle", a_idle, 1);
        chk("rst_mid_ostart0", a_ostart, 0);
        chk("rst_mid_onum", a_onum, 0);
        chk("rst_mid_xfer", a_xfer, 0);
        chk("rst_mid_busy", a_busy, 0);
        step;
        rst_n = 1'b1;
        a_idone = 1'b1;
        d0 = a_done_cnt;
        step;
        a_idone = 1'b0;
        repeat (6) step;
        chk("rst_mid_no_done", a_done_cnt - d0, 0);
        chk("rst_mid_idle_after", a_idle, 1);
        run_a(vecs[0]);

        // three sinks, bit0 pulsed twice, ap_ctrl_hs
        b_num = 64'd10; b_start = 1'b1;
        step;
        b_start = 1'b0;
        step;
        chk("b_ostart", b_ostart, 1);
        chk("b_ready", b_ready, 1);
        chk("b_xfer0", b_xfer[15:0], 16'd640);
        chk("b_xfer1", b_xfer[31:16], 16'd320);
        early = 1'b0;
        for (int i = 0; i < 13; i++) begin
            b_idone = (i == 5) ? 3'b001 : (i == 9) ? 3'b011 : (i == 12) ? 3'b100 : 3'b000;
            if (b_done) early = 1'b1;
            step;
        end
        b_idone = 3'b000;
        chk("b_no_early_done", early, 0);
        chk("b_done", b_done, 1);
        chk("b_busy", b_busy, 13);
        step;
        chk("b_done_pulse", b_done, 0);
        chk("b_idle", b_idle, 1);

        // 16-bit byte count overflow
        s0 = b_start_cnt;
        b_num = 64'd2048; b_start = 1'b1;
        step;
        b_start = 1'b0;
        step;
        chk("b_ovf_done", b_done, 1);
        chk("b_ovf_ready", b_ready, 1);
        chk("b_ovf_err", b_err, 1);
        chk("b_ovf_ostart", b_ostart, 0);
        step;
        chk("b_ovf_done_end", b_done, 0);
        chk("b_ovf_busy", b_busy, 0);
        chk("b_ovf_start_cnt", b_start_cnt - s0, 0);

        // ap_start held high across two back-to-back commands
        b_num = 64'd3; b_start = 1'b1;
        obs_start = '0; obs_done = '0; obs_idle = '0;
        for (int i = 0; i < 8; i++) begin
            step;
            obs_start[i] = b_ostart;
            obs_done[i]  = b_done;
            obs_idle[i]  = b_idle;
            b_idone = b_ostart ? 3'b111 : 3'b000;
            if (i == 5) b_start = 1'b0;
        end
        b_idone = 3'b000;
        chk("b2_start_seq", obs_start, 8'b0010_0010);
        chk("b2_done_seq", obs_done, 8'b0100_0100);
        chk("b2_idle_seq", obs_idle, 8'b1000_1000);
        chk("b2_err_clear", b_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
